// File: rtl/jt89_pkg.sv
// Shared constants and types for the jt89 host-side write sequencer.
// Latch-byte layout, command bundle and PSG reset values.
package jt89_pkg;

  localparam logic KIND_TONE = 1'b0;
  localparam logic KIND_VOL  = 1'b1;

  localparam logic [1:0] CH_NOISE = 2'd3;

  localparam int LB_FLAG  = 7;
  localparam int LB_CH_HI = 6;
  localparam int LB_CH_LO = 5;
  localparam int LB_TYPE  = 4;

  localparam logic [3:0] VOL_RST   = 4'hF;
  localparam logic [9:0] TONE_RST  = 10'd0;
  localparam logic [2:0] CTRL3_RST = 3'b100;

  typedef struct packed {
    logic [1:0] ch;
    logic       kind;
    logic [9:0] val;
  } cmd_t;

  function automatic logic [7:0] latch_byte(
    input logic [1:0] ch,
    input logic       typ,
    input logic [3:0] data
  );
    logic [7:0] b;
    b                    = '0;
    b[LB_FLAG]           = 1'b1;
    b[LB_CH_HI:LB_CH_LO] = ch;
    b[LB_TYPE]           = typ;
    b[3:0]               = data;
    return b;
  endfunction

endpackage

// File: rtl/jt89_cmd_fifo.sv
// Command FIFO for the jt89 write sequencer.
// Power-of-two depth, occupancy counter, async reset.
module jt89_cmd_fifo
  import jt89_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign rdata   = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/jt89_wrseq.sv
// Host-side write sequencer driving the jt89 wr_n/din port.
// Encodes channel commands into SN76489 bytes, one clk_en edge each.
module jt89_wrseq
  import jt89_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 1,
  parameter int SKIP_DUP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic       cmd_kind,
  input  logic [9:0] cmd_val,
  output logic       wr_n,
  output logic [7:0] din,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
  localparam bit SKIP = (SKIP_DUP != 0);

  logic [1:0]    st;
  cmd_t          fifo_in;
  cmd_t          fifo_out;
  cmd_t          cq;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [GW-1:0] gcnt;
  logic [7:0]    dt_q;
  logic          more;
  logic [3:0]    vol_sh [4];
  logic [9:0]    tone_sh [3];
  logic [9:0]    tone_cur;
  logic [7:0]    lt;
  logic [7:0]    dt;
  logic [1:0]    nb;

  assign fifo_in   = {cmd_ch, cmd_kind, cmd_val};
  assign push      = cmd_valid && !full;
  assign pop       = (st == ST_IDLE) && !empty;
  assign cmd_ready = !full;
  assign busy      = !empty || (st != ST_IDLE);

  jt89_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_in),
    .rdata (fifo_out),
    .full  (full),
    .empty (empty)
  );

  // shadow of the tone period for the channel being decoded
  always_comb begin
    case (cq.ch)
      2'd0:    tone_cur = tone_sh[0];
      2'd1:    tone_cur = tone_sh[1];
      2'd2:    tone_cur = tone_sh[2];
      default: tone_cur = TONE_RST;
    endcase
  end

  // byte list for the held command; noise ctrl is never suppressed
  // because writing it restarts the noise LFSR
  always_comb begin
    lt = '0;
    dt = '0;
    nb = 2'd0;
    if (cq.kind == KIND_VOL) begin
      lt = latch_byte(cq.ch, 1'b1, cq.val[3:0]);
      if (SKIP && vol_sh[cq.ch] == cq.val[3:0]) nb = 2'd0;
      else nb = 2'd1;
    end else if (cq.ch == CH_NOISE) begin
      lt = latch_byte(CH_NOISE, 1'b0, {1'b0, cq.val[2:0]});
      nb = 2'd1;
    end else begin
      lt = latch_byte(cq.ch, 1'b0, cq.val[3:0]);
      dt = {2'b00, cq.val[9:4]};
      if (SKIP && tone_cur == cq.val) nb = 2'd0;
      else if (SKIP && tone_cur[9:4] == cq.val[9:4]) nb = 2'd1;
      else nb = 2'd2;
    end
  end

  // sequencer: pop, decode, strobe each byte on one clk_en edge, gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= ST_IDLE;
      cq   <= '0;
      wr_n <= 1'b1;
      din  <= '0;
      gcnt <= '0;
      dt_q <= '0;
      more <= 1'b0;
      for (int i = 0; i < 4; i++) vol_sh[i] <= VOL_RST;
      for (int i = 0; i < 3; i++) tone_sh[i] <= TONE_RST;
    end else begin
      case (st)
        ST_IDLE: begin
          if (!empty) begin
            cq <= fifo_out;
            st <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (nb == 2'd0) begin
            st <= ST_IDLE;
          end else begin
            din  <= lt;
            wr_n <= 1'b0;
            dt_q <= dt;
            more <= (nb == 2'd2);
            st   <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (clk_en) begin
            wr_n <= 1'b1;
            gcnt <= GAP_LOAD;
            st   <= ST_GAP;
            if (!more) begin
              if (cq.kind == KIND_VOL) vol_sh[cq.ch] <= cq.val[3:0];
              else if (cq.ch != CH_NOISE) tone_sh[cq.ch] <= cq.val;
            end
          end
        end
        default: begin
          if (clk_en) begin
            if (gcnt == '0) begin
              if (more) begin
                din  <= dt_q;
                wr_n <= 1'b0;
                more <= 1'b0;
                st   <= ST_STROBE;
              end else begin
                st <= ST_IDLE;
              end
            end else begin
              gcnt <= gcnt - 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt89_wrseq.sv
// Directed bench for jt89_wrseq with a byte scoreboard.
// Monitor checks one clk_en edge per strobe and the inter-byte gap.
module tb_jt89_wrseq;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en = 1'b0;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ch;
  logic       cmd_kind;
  logic [9:0] cmd_val;
  logic       wr_n;
  logic [7:0] din;
  logic       busy;

  int n_pass = 0;
  int n_tot = 0;
  int n_fail = 0;
  int n_bytes = 0;
  int cen_mode = 0;
  int cen_cnt = 0;
  int low_edges = 0;
  int gap_edges = 0;
  bit prev_low = 0;
  bit have_prev = 0;
  logic [7:0] sb[$];

  jt89_wrseq #(
    .FIFO_DEPTH (4),
    .GAP        (1),
    .SKIP_DUP   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_kind  (cmd_kind),
    .cmd_val   (cmd_val),
    .wr_n      (wr_n),
    .din       (din),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // clk_en pattern: 0 stuck low, 1 stuck high, 4 every 4th clk
  always @(posedge clk) begin
    #1;
    cen_cnt++;
    clk_en = (cen_mode == 1) || (cen_mode == 4 && cen_cnt % 4 == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // PSG-side view: values at negedge are what the next posedge samples
  always @(negedge clk) begin
    if (rst) begin
      prev_low  = 0;
      have_prev = 0;
      low_edges = 0;
      gap_edges = 0;
    end else if (!wr_n) begin
      if (!prev_low) begin
        if (have_prev) chk("gap_edges", 32'(gap_edges >= 1), 1);
        low_edges = 0;
      end
      if (clk_en) begin
        low_edges++;
        n_bytes++;
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("din", din, sb.pop_front());
      end
      prev_low = 1;
    end else begin
      if (prev_low) begin
        chk("strobe_edges", low_edges, 1);
        gap_edges = 0;
        have_prev = 1;
      end
      if (clk_en) gap_edges++;
      prev_low = 0;
    end
  end

  task automatic send(input logic [1:0] ch, input logic k,
                      input logic [9:0] v, input int nb,
                      input logic [7:0] b0, input logic [7:0] b1);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_ch = ch;
    cmd_kind = k;
    cmd_val = v;
    @(negedge clk);
    while (!cmd_ready && t < 400) begin
      t++;
      @(negedge clk);
    end
    chk("accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (nb > 0) sb.push_back(b0);
    if (nb > 1) sb.push_back(b1);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 2000) begin
      t++;
      @(negedge clk);
    end
    chk(tag, busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_low(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (wr_n && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk(tag, wr_n, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_ch = '0;
    cmd_kind = 1'b0;
    cmd_val = '0;
    #12;
    chk("rst_wr_n", wr_n, 1);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    cen_mode = 4;
    send(2'd0, 1'b0, 10'h2A5, 2, 8'h85, 8'h2A);
    wait_idle("idle_tone0");

    n0 = n_bytes;
    send(2'd1, 1'b1, 10'h003, 1, 8'hB3, 8'h00);
    send(2'd1, 1'b1, 10'h3F3, 0, 8'h00, 8'h00);
    wait_idle("idle_dup");
    chk("dup_bytes", n_bytes - n0, 1);

    n0 = n_bytes;
    send(2'd3, 1'b0, 10'h005, 1, 8'hE5, 8'h00);
    send(2'd3, 1'b0, 10'h3FD, 1, 8'hE5, 8'h00);
    send(2'd3, 1'b1, 10'h000, 1, 8'hF0, 8'h00);
    wait_idle("idle_noise");
    chk("noise_bytes", n_bytes - n0, 3);

    n0 = n_bytes;
    send(2'd2, 1'b0, 10'h2A5, 2, 8'hC5, 8'h2A);
    send(2'd2, 1'b0, 10'h2A7, 1, 8'hC7, 8'h00);
    wait_idle("idle_tone2");
    chk("tone2_bytes", n_bytes - n0, 3);

    cen_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(2'd0, 1'b1, 10'h005, 1, 8'h95, 8'h00);
    chk("lat0", wr_n, 1);
    @(posedge clk);
    #1;
    chk("lat1", wr_n, 1);
    @(posedge clk);
    #1;
    chk("lat2", wr_n, 0);
    @(posedge clk);
    #1;
    chk("lat3", wr_n, 1);
    wait_idle("idle_lat");
    send(2'd1, 1'b0, 10'h3C1, 2, 8'hA1, 8'h3C);
    wait_idle("idle_high");

    cen_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(2'd0, 1'b1, 10'h001, 1, 8'h91, 8'h00);
    wait_low("stall_low");
    send(2'd1, 1'b1, 10'h007, 1, 8'hB7, 8'h00);
    send(2'd2, 1'b1, 10'h008, 1, 8'hD8, 8'h00);
    send(2'd1, 1'b0, 10'h123, 2, 8'hA3, 8'h12);
    send(2'd3, 1'b1, 10'h009, 1, 8'hF9, 8'h00);
    cmd_valid = 1'b1;
    cmd_ch = 2'd0;
    cmd_kind = 1'b1;
    cmd_val = 10'h002;
    @(negedge clk);
    chk("full_ready", cmd_ready, 0);
    repeat (20) @(negedge clk);
    chk("stall_wr_n", wr_n, 0);
    chk("stall_ready", cmd_ready, 0);
    chk("stall_busy", busy, 1);
    @(posedge clk);
    #1;
    cen_mode = 4;
    send(2'd0, 1'b1, 10'h002, 1, 8'h92, 8'h00);
    wait_idle("idle_drain");
    chk("drain_sb", sb.size(), 0);

    cen_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(2'd0, 1'b1, 10'h004, 0, 8'h00, 8'h00);
    wait_low("rst_low");
    rst = 1'b1;
    #1;
    chk("rst_mid_wr_n", wr_n, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cen_mode = 4;
    n0 = n_bytes;
    send(2'd0, 1'b1, 10'h00F, 0, 8'h00, 8'h00);
    wait_idle("idle_rst_dup");
    repeat (20) @(posedge clk);
    #1;
    chk("rst_dup_bytes", n_bytes - n0, 0);

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/jt89_wrseq.md
Name: jt89_wrseq

Overview:
Host-side write sequencer for the jt89 PSG write port; the transmitting end of the wr_n/din byte protocol.
- Accepts per-channel commands (tone period, volume, noise control) over a valid/ready handshake and buffers them in a small FIFO.
- Encodes each command into SN76489 latch and data bytes, keeping a shadow register copy to suppress redundant writes.
- Strobes each byte so the PSG, enabled by the same clk_en, samples it exactly once.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
GAP, 1, clk_en ticks with wr_n high between consecutive bytes; minimum 1.
SKIP_DUP, 1, 1 = drop commands equal to the shadow copy; 0 = always write.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
clk_en  in  1  PSG clock enable; the same signal that drives the jt89 clk_en.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO not full; a command is accepted when cmd_valid & cmd_ready.
cmd_ch  in  2  channel 0-2 tone, 3 noise.
cmd_kind  in  1  0 = tone period / noise ctrl, 1 = volume.
cmd_val  in  10  tone period [9:0]; volume uses [3:0]; noise ctrl uses [2:0].
wr_n  out  1  PSG write strobe, active low.
din  out  8  PSG write data.
busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
Reset values (async): wr_n=1, din=0, busy=0, cmd_ready=1, FIFO empty, FSM=IDLE.
- Shadow registers reset to the PSG reset state: vol0-3=4'hF, tone0-2=0, ctrl3=3'b100.

FIFO:
- Push on cmd_valid & cmd_ready.
- Pop only in IDLE.
- Simultaneous push and pop is legal; the count is unchanged.
- When full, cmd_ready=0.
- Pointers wrap modulo FIFO_DEPTH.

Encoding (lt = latch byte, dt = data byte):
- Tone, ch 0-2, kind 0: lt = {1, ch, 0, val[3:0]}, then dt = {2'b00, val[9:4]}.
- Volume, any ch, kind 1: lt only = {1, ch, 1, val[3:0]}.
- Noise ctrl, ch 3, kind 0: lt only = {1, 2'b11, 0, 1'b0, val[2:0]}.

Duplicate suppression (SKIP_DUP=1):
- Volume/tone command equal to its shadow: discarded, no bus activity, costs 1 clk in DECODE.
- Tone with val[9:4] equal to shadow[9:4] but val[3:0] different: lt only.
- Noise ctrl is always written, because a ctrl3 write resets the noise LFSR.
- Shadows update when the last byte of a command completes.

FSM states: IDLE, DECODE, STROBE, GAP.
- IDLE: if FIFO non-empty, pop into the command register -> DECODE.
- DECODE: build the byte list (0, 1 or 2 bytes).
  - 0 bytes -> IDLE.
  - Otherwise din <= first byte, wr_n <= 0 -> STROBE.
- STROBE: hold din and wr_n=0 until an edge with clk_en=1. The PSG samples wr_n=0 at that edge.
  - At the same edge: wr_n <= 1, gap counter <= GAP-1 -> GAP.
  - Exactly one clk_en edge sees each byte, whatever the clk_en phase when STROBE was entered.
- GAP: wr_n=1; din holds its value. Decrement the counter on each clk_en edge. At zero with a clk_en edge:
  - Another byte pending: din <= next byte, wr_n <= 0 -> STROBE.
  - No byte pending: -> IDLE.
- Latency: accept to wr_n low = 3 clk minimum (push, IDLE pop, DECODE).

Boundary conditions:
- clk_en stuck low: the FSM waits in STROBE indefinitely; the FIFO keeps accepting until full.
- clk_en stuck high: each byte has wr_n low for 1 clk and high for GAP clks.
- Reset mid-STROBE: wr_n returns to 1 immediately (async). The partially sent command is lost and the shadows revert.
- cmd_val bits outside the field a kind uses are ignored.

Decomposition:
- Package jt89_pkg:
  - kind constants KIND_TONE=0, KIND_VOL=1;
  - noise channel code CH_NOISE=2'd3;
  - latch-byte bit positions;
  - PSG reset constants VOL_RST=4'hF, TONE_RST=10'd0, CTRL3_RST=3'b100.
- Sub-module jt89_cmd_fifo: synchronous FIFO, 13-bit entries {ch, kind, val}, outputs full and empty, async reset.

Test Plan:
- Tone ch0 val 10'h2A5, clk_en every 4th clk -> din 0x85 then 0x2A. Each byte has exactly one clk_en edge with wr_n=0, and ≥GAP clk_en edges high between them.
- Volume ch1 val 3, then volume ch1 val 3 again (SKIP_DUP=1) -> one byte 0xB3; the second command produces no wr_n activity and busy drops.
- Noise ctrl 3'b101 issued twice -> 0xE5 written twice. Volume ch3 val 0 -> 0xF0.
- Tone ch2 10'h2A5, then 10'h2A7 -> second command emits only 0xC7.
- Push 5 commands with clk_en=0 and FIFO_DEPTH=4 -> cmd_ready low after 4 accepted. Enabling clk_en drains them all in order.
- Assert rst while wr_n=0 in STROBE -> wr_n=1 the same cycle, FIFO empty. A following vol0=4'hF command is suppressed (shadow back to reset).
